// File: rtl/btn_event_gen_if.sv
// Button event bus: raw pins in, debounced levels and one-cycle events out.
// The slave modport is the event generator; the master is whoever drives the
// pins and consumes the events.
interface btn_event_gen_if #(
  parameter int N = 4
) ();
  logic [N-1:0] btn;
  logic [N-1:0] lvl;
  logic [N-1:0] press;
  logic [N-1:0] release_pulse;
  logic [N-1:0] repeat_pulse;
  logic         chord;
  logic [N-1:0] chord_map;

  modport master (
    output btn,
    input  lvl, press, release_pulse, repeat_pulse, chord, chord_map
  );

  modport slave (
    input  btn,
    output lvl, press, release_pulse, repeat_pulse, chord, chord_map
  );
endinterface

// File: rtl/btn_event_gen.sv
// N-button debouncer feeding a press / release / auto-repeat / chord engine.
// All event outputs are registered and appear one cycle after the debounced
// level change that causes them.
//
// state   | meaning
// --------+-----------------------------------------------------------------
// S_IDLE  | no button held
// S_SOLO  | exactly one button (owner) held; repeat timer running
// S_CHORD | multi-button gesture in progress; map accumulates every press
module btn_event_gen #(
  parameter int   N        = 4,
  parameter logic RV       = 1'b1,
  parameter int   DBW      = 12,
  parameter int   DEB_CYC  = 2499,
  parameter int   HBW      = 24,
  parameter int   HOLD_CYC = 12499999,
  parameter int   RPT_CYC  = 2499999
) (
  input logic             clk,
  input logic             rstx,
  btn_event_gen_if.slave  bus
);

  localparam int              OW       = $clog2(N);
  localparam logic [N-1:0]    IDLE_LVL = {N{RV}};
  localparam logic [DBW-1:0]  DEB_T    = DBW'(DEB_CYC);
  localparam logic [HBW-1:0]  HOLD_T   = HBW'(HOLD_CYC);
  localparam logic [HBW-1:0]  RPT_T    = HBW'(RPT_CYC);

  typedef enum logic [1:0] {S_IDLE, S_SOLO, S_CHORD} state_t;

  logic [N-1:0]   sync1, sync2;
  logic [N-1:0]   pressed_sync;
  logic [N-1:0]   stable;
  logic [N-1:0]   stable_d;
  logic [N-1:0]   rise;
  logic           rise_one_hot;
  logic [OW-1:0]  rise_idx;

  state_t         state, state_nxt;
  logic [OW-1:0]  owner, owner_nxt;
  logic [N-1:0]   owner_bit;
  logic [N-1:0]   other_rise;
  logic [N-1:0]   map, map_nxt;
  logic [HBW-1:0] hold_cnt, hold_nxt, hold_inc, hold_term;
  logic           in_rpt, in_rpt_nxt;

  logic [N-1:0]   press_q, press_nxt;
  logic [N-1:0]   rel_q, rel_nxt;
  logic [N-1:0]   rpt_q, rpt_nxt;
  logic           chord_q, chord_nxt;
  logic [N-1:0]   chord_map_q, chord_map_nxt;

  // Two-flop synchroniser; resets to the idle pin level so a held button
  // is seen as a fresh press once reset lifts.
  always_ff @(posedge clk or negedge rstx) begin
    if (!rstx) begin
      sync1 <= IDLE_LVL;
      sync2 <= IDLE_LVL;
    end else begin
      sync1 <= bus.btn;
      sync2 <= sync1;
    end
  end

  assign pressed_sync = sync2 ^ IDLE_LVL;

  for (genvar g = 0; g < N; g++) begin : g_deb
    logic [DBW-1:0] deb_cnt;
    logic           stb;

    // Accept a new level only after it has differed for DEB_CYC+1 cycles.
    always_ff @(posedge clk or negedge rstx) begin
      if (!rstx) begin
        deb_cnt <= '0;
        stb     <= 1'b0;
      end else if (pressed_sync[g] == stb) begin
        deb_cnt <= '0;
      end else if (deb_cnt == DEB_T) begin
        stb     <= pressed_sync[g];
        deb_cnt <= '0;
      end else begin
        deb_cnt <= deb_cnt + DBW'(1);
      end
    end

    assign stable[g] = stb;
  end

  // Previous debounced level, for rising-edge detection.
  always_ff @(posedge clk or negedge rstx) begin
    if (!rstx) stable_d <= '0;
    else       stable_d <= stable;
  end

  assign rise         = stable & ~stable_d;
  assign rise_one_hot = (rise != '0) && ((rise & (rise - N'(1))) == '0);
  assign owner_bit    = N'(1) << owner;
  assign other_rise   = rise & ~owner_bit;
  assign hold_inc     = (hold_cnt == '1) ? hold_cnt : hold_cnt + HBW'(1);
  assign hold_term    = in_rpt ? RPT_T : HOLD_T;

  // Index of the rising button; only meaningful when exactly one rises.
  always_comb begin
    rise_idx = '0;
    for (int i = 0; i < N; i++) begin
      if (rise[i]) rise_idx = OW'(i);
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rstx) begin
    if (!rstx) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // FSM next-state decode.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (rise_one_hot)     state_nxt = S_SOLO;
        else if (rise != '0)  state_nxt = S_CHORD;
      end
      S_SOLO: begin
        if (other_rise != '0)   state_nxt = S_CHORD;
        else if (!stable[owner]) state_nxt = (stable == '0) ? S_IDLE : S_CHORD;
      end
      S_CHORD: begin
        if (stable == '0) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // FSM outputs and datapath next values (owner, chord map, repeat timer).
  always_comb begin
    press_nxt     = '0;
    rel_nxt       = '0;
    rpt_nxt       = '0;
    chord_nxt     = 1'b0;
    chord_map_nxt = chord_map_q;
    owner_nxt     = owner;
    map_nxt       = map;
    hold_nxt      = hold_cnt;
    in_rpt_nxt    = in_rpt;
    case (state)
      S_IDLE: begin
        if (rise_one_hot) begin
          press_nxt  = rise;
          owner_nxt  = rise_idx;
          hold_nxt   = '0;
          in_rpt_nxt = 1'b0;
        end else if (rise != '0) begin
          map_nxt = rise;
        end
      end
      S_SOLO: begin
        if (other_rise != '0) begin
          map_nxt    = owner_bit | other_rise;
          hold_nxt   = '0;
          in_rpt_nxt = 1'b0;
        end else if (!stable[owner]) begin
          // A non-owner level held without a rise cannot normally occur;
          // treat it as a chord rather than reporting a solo release.
          if (stable == '0) rel_nxt = owner_bit;
          else              map_nxt = owner_bit | stable;
          hold_nxt   = '0;
          in_rpt_nxt = 1'b0;
        end else if (HOLD_CYC != 0) begin
          // First terminal is HOLD_CYC after PRESS, then every RPT_CYC.
          if (hold_inc == hold_term) begin
            rpt_nxt    = owner_bit;
            hold_nxt   = '0;
            in_rpt_nxt = 1'b1;
          end else begin
            hold_nxt = hold_inc;
          end
        end
      end
      S_CHORD: begin
        map_nxt = map | rise;
        if (stable == '0) begin
          chord_nxt     = 1'b1;
          chord_map_nxt = map | rise;
        end
      end
      default: ;
    endcase
  end

  // Registered events and datapath.
  always_ff @(posedge clk or negedge rstx) begin
    if (!rstx) begin
      owner       <= '0;
      map         <= '0;
      hold_cnt    <= '0;
      in_rpt      <= 1'b0;
      press_q     <= '0;
      rel_q       <= '0;
      rpt_q       <= '0;
      chord_q     <= 1'b0;
      chord_map_q <= '0;
    end else begin
      owner       <= owner_nxt;
      map         <= map_nxt;
      hold_cnt    <= hold_nxt;
      in_rpt      <= in_rpt_nxt;
      press_q     <= press_nxt;
      rel_q       <= rel_nxt;
      rpt_q       <= rpt_nxt;
      chord_q     <= chord_nxt;
      chord_map_q <= chord_map_nxt;
    end
  end

  assign bus.lvl           = stable;
  assign bus.press         = press_q;
  assign bus.release_pulse = rel_q;
  assign bus.repeat_pulse  = rpt_q;
  assign bus.chord         = chord_q;
  assign bus.chord_map     = chord_map_q;

endmodule

// File: tb/tb_btn_event_gen.sv
// Directed bench for btn_event_gen with N=4, DEB_CYC=3, HOLD_CYC=10, RPT_CYC=4.
// Pins are driven 1 time unit after a rising edge ("cycle 0"); outputs are
// sampled 1 time unit after each later edge, so cycle k is after edge k.
module tb_btn_event_gen;
  logic clk = 1'b0;
  logic rstx;
  int   tests = 0;
  int   fails = 0;

  btn_event_gen_if #(.N(4)) bus ();

  btn_event_gen #(
    .N(4), .RV(1'b1), .DBW(4), .DEB_CYC(3),
    .HBW(8), .HOLD_CYC(10), .RPT_CYC(4)
  ) dut (
    .clk(clk),
    .rstx(rstx),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input int c, input logic [3:0] obs, input logic [3:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s cyc %0d: got %b want %b", tag, c, obs, exp);
    end
  endtask

  task automatic chk_all(input string sc, input int c,
                         input logic [3:0] e_lvl, input logic [3:0] e_press,
                         input logic [3:0] e_rel, input logic [3:0] e_rpt,
                         input logic e_chord, input logic [3:0] e_map);
    chk({sc, ".lvl"},     c, bus.lvl,           e_lvl);
    chk({sc, ".press"},   c, bus.press,         e_press);
    chk({sc, ".release"}, c, bus.release_pulse, e_rel);
    chk({sc, ".repeat"},  c, bus.repeat_pulse,  e_rpt);
    chk({sc, ".chord"},   c, {3'b000, bus.chord}, {3'b000, e_chord});
    chk({sc, ".map"},     c, bus.chord_map,     e_map);
  endtask

  initial begin
    rstx    = 1'b0;
    bus.btn = 4'b1111;
    repeat (3) @(posedge clk);
    #1;
    chk_all("reset", 0, 4'b0, 4'b0, 4'b0, 4'b0, 1'b0, 4'b0);
    rstx = 1'b1;
    repeat (4) tick();
    chk_all("idle", 0, 4'b0, 4'b0, 4'b0, 4'b0, 1'b0, 4'b0);

    // 1: solo press/release of button 0; held 20 cycles so the repeat
    // timer fires at 17, 21, 25 before LVL drops at 26.
    bus.btn = 4'b1110;
    for (int c = 1; c <= 34; c++) begin
      tick();
      chk_all("s1", c,
              (c >= 6 && c < 26) ? 4'b0001 : 4'b0000,
              (c == 7) ? 4'b0001 : 4'b0000,
              (c == 27) ? 4'b0001 : 4'b0000,
              (c == 17 || c == 21 || c == 25) ? 4'b0001 : 4'b0000,
              1'b0, 4'b0000);
      if (c == 20) bus.btn = 4'b1111;
    end

    // 2a: 3-cycle glitch on button 1 is rejected.
    bus.btn = 4'b1101;
    for (int c = 1; c <= 12; c++) begin
      tick();
      chk_all("s2_glitch", c, 4'b0, 4'b0, 4'b0, 4'b0, 1'b0, 4'b0);
      if (c == 3) bus.btn = 4'b1111;
    end

    // 2b: 4-cycle pulse on button 1 is accepted (rise 6, fall 10).
    bus.btn = 4'b1101;
    for (int c = 1; c <= 16; c++) begin
      tick();
      chk_all("s2_pulse", c,
              (c >= 6 && c < 10) ? 4'b0010 : 4'b0000,
              (c == 7) ? 4'b0010 : 4'b0000,
              (c == 11) ? 4'b0010 : 4'b0000,
              4'b0000, 1'b0, 4'b0000);
      if (c == 4) bus.btn = 4'b1111;
    end

    // 3: auto-repeat on button 2 held 40 cycles.
    bus.btn = 4'b1011;
    for (int c = 1; c <= 55; c++) begin
      tick();
      chk_all("s3", c,
              (c >= 6 && c < 46) ? 4'b0100 : 4'b0000,
              (c == 7) ? 4'b0100 : 4'b0000,
              (c == 47) ? 4'b0100 : 4'b0000,
              (c >= 17 && c <= 45 && ((c - 17) % 4) == 0) ? 4'b0100 : 4'b0000,
              1'b0, 4'b0000);
      if (c == 40) bus.btn = 4'b1111;
    end

    // 4: button 0 then button 3 five cycles later -> chord 1001.
    bus.btn = 4'b1110;
    for (int c = 1; c <= 32; c++) begin
      tick();
      chk_all("s4", c,
              ((c >= 6 && c < 26) ? 4'b0001 : 4'b0000) |
              ((c >= 11 && c < 26) ? 4'b1000 : 4'b0000),
              (c == 7) ? 4'b0001 : 4'b0000,
              4'b0000, 4'b0000,
              (c == 27),
              (c >= 27) ? 4'b1001 : 4'b0000);
      if (c == 5)  bus.btn = 4'b0110;
      if (c == 20) bus.btn = 4'b1111;
    end

    // 5: buttons 1 and 2 together -> chord 0110, previous map held until then.
    bus.btn = 4'b1001;
    for (int c = 1; c <= 22; c++) begin
      tick();
      chk_all("s5", c,
              (c >= 6 && c < 16) ? 4'b0110 : 4'b0000,
              4'b0000, 4'b0000, 4'b0000,
              (c == 17),
              (c >= 17) ? 4'b0110 : 4'b1001);
      if (c == 10) bus.btn = 4'b1111;
    end

    // 6: reset during a repeat sequence on button 2.
    bus.btn = 4'b1011;
    for (int c = 1; c <= 23; c++) begin
      tick();
      chk_all("s6_hold", c,
              (c >= 6) ? 4'b0100 : 4'b0000,
              (c == 7) ? 4'b0100 : 4'b0000,
              4'b0000,
              (c == 17 || c == 21) ? 4'b0100 : 4'b0000,
              1'b0, 4'b0110);
    end
    rstx = 1'b0;
    #1;
    chk_all("s6_rst", 0, 4'b0, 4'b0, 4'b0, 4'b0, 1'b0, 4'b0);
    tick();
    tick();
    chk_all("s6_rst_hold", 2, 4'b0, 4'b0, 4'b0, 4'b0, 1'b0, 4'b0);
    rstx = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      tick();
      chk_all("s6_after", c,
              (c >= 6) ? 4'b0100 : 4'b0000,
              (c == 7) ? 4'b0100 : 4'b0000,
              4'b0000, 4'b0000, 1'b0, 4'b0000);
    end
    bus.btn = 4'b1111;
    for (int c = 1; c <= 10; c++) begin
      tick();
      chk_all("s6_rel", c,
              (c < 6) ? 4'b0100 : 4'b0000,
              4'b0000,
              (c == 7) ? 4'b0100 : 4'b0000,
              4'b0000, 1'b0, 4'b0000);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
